// File: rtl/scale_mux_arb_if.sv
// rtl/scale_mux_arb_if.sv - NUM_CH valid/ready input channels plus one registered output stream
interface scale_mux_arb_if #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) ();
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic [CH_W-1:0]         out_ch;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/scale_mux_arb.sv
// rtl/scale_mux_arb.sv - NUM_CH:1 valid/ready mux with fixed-priority or round-robin arbitration
module scale_mux_arb #(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic clk,
  input  logic rst,
  input  logic mode_rr,
  scale_mux_arb_if.slave bus
);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   grant_idx;
  logic              found;
  logic [CH_W:0]     idx;
  logic              load;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   next_ptr;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [CH_W-1:0]   out_ch_q;

  assign load = ~out_valid_q | bus.out_ready;

  // Search order starts at rr_ptr in round-robin mode, at 0 in fixed mode; first valid wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (mode_rr ? {1'b0, rr_ptr} : {(CH_W+1){1'b0}}) + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) begin
        idx = idx - (CH_W+1)'(NUM_CH);
      end
      if (!found && bus.in_valid[idx[CH_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[CH_W-1:0];
      end
    end
    if (found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign next_ptr = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + 1'b1;

  assign bus.in_ready  = grant & {NUM_CH{load & ~rst}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr      <= '0;
    end else if (load) begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus.in_data[grant_idx*WIDTH +: WIDTH];
        out_ch_q    <= grant_idx;
        rr_ptr      <= next_ptr;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: doc/scale_mux_arb.md
Name: scale_mux_arb

Overview:
- Parametrised successor to the 2:1 byte scale mux: selects one of NUM_CH valid/ready input channels of WIDTH bits and forwards it through a single registered output stage.
- Arbitration is runtime-selectable: fixed priority or round-robin.
- Used wherever several producers share one downstream consumer, in place of a hand-driven select line.

Parameters:
- WIDTH, 8, data width of every channel and of the output.
- NUM_CH, 4, number of input channels; must be ≥2.
- CH_W, $clog2(NUM_CH), width of the channel-index output (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mode_rr  input  1  0 = fixed priority (lowest index wins); 1 = round-robin.
- in_valid  input  NUM_CH  per-channel valid.
- in_data  input  NUM_CH*WIDTH  flattened data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  output  NUM_CH  per-channel ready; one-hot or all-zero.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream ready.
- out_data  output  WIDTH  registered output data.
- out_ch  output  CH_W  index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at an edge): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is forced to all zero while rst=1.
- Reset mid-operation: any held output word is discarded. No input is accepted during the reset cycle.
- Load condition: load = ~out_valid | out_ready.
  - Combinational in_ready[i] = load & grant[i] & ~rst.
  - A transfer on channel i occurs when in_valid[i] & in_ready[i].
- Grant is combinational from in_valid and is one-hot or zero.
  - mode_rr=0: lowest-index valid channel wins.
  - mode_rr=1: search starts at rr_ptr, ascends and wraps NUM_CH-1→0; first valid channel wins.
- On a clock edge with load=1:
  - If any in_valid: out_data<=in_data of the granted channel, out_ch<=granted index, out_valid<=1.
  - Else: out_valid<=0; out_data and out_ch hold their previous values.
- On a clock edge with load=0 (out_valid=1, out_ready=0): out_valid, out_data and out_ch hold. in_ready is all zero.
- Latency: one cycle from input transfer to out_valid. Throughput: one word per cycle when out_ready is held at 1.
- rr_ptr updates only on a transfer: rr_ptr <= (granted index + 1) mod NUM_CH, with wrap at NUM_CH-1→0. It updates in both modes, so switching to round-robin resumes after the last served channel.
- A change on mode_rr takes effect on the arbitration in that same cycle. There is no internal mode latch.
- A simultaneous out_ready handshake and new input capture in the same cycle is legal and loses no data.
- An input whose in_valid is withdrawn without a transfer is not an error. The block only samples at transfer.
- No combinational path from in_data to the out_* ports.

Test Plan:
- Reset check (WIDTH=8, NUM_CH=4): drive rst=1 with in_valid=4'b1111 → in_ready=0000, out_valid=0, out_data=8'h00, out_ch=0 after the edge.
- Fixed priority: mode_rr=0, out_ready=1, in_valid=4'b1010, data ch1=8'hA1, ch3=8'hC3, held for 3 cycles → out_data=A1/out_ch=1 each cycle; ch3 is never granted.
- Round-robin fairness: mode_rr=1, out_ready=1, in_valid=4'b1111, data ch0..3=8'h00,8'hFF,8'h0F,8'hF0 → out_ch sequence 0,1,2,3,0 (wrap) with matching out_data, one word per cycle.
- Backpressure: capture ch2=8'h5A, then out_ready=0 for 3 cycles while ch1 is valid → out_valid=1, out_data=5A, out_ch=2 stable and in_ready=0000. Then out_ready=1 → 5A accepted and ch1 loaded on that edge.
- Mode switch: in fixed mode serve ch0 (rr_ptr→1), then set mode_rr=1 with in_valid=4'b0011 → ch1 is granted next, not ch0.
- Mid-stream reset: out_valid=1 holding 8'hFF with out_ready=0, assert rst for one cycle → out_valid=0, out_data=0. After release with in_valid=4'b0001 in round-robin mode, ch0 is granted (rr_ptr=0).
